// File: rtl/sweep_pkg.sv
// Shared types and default constants for the truth-table sweep block.
//   state_t               : sweep controller state encoding
//   DEFAULT_SETTLE_CYCLES : cycles each {x,y} vector is held before z is sampled
//   DEFAULT_EXPECTED      : golden truth table indexed by {x,y} (2-input AND)
package sweep_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned TBL_W = 4;

   localparam int unsigned     DEFAULT_SETTLE_CYCLES = 100;
   localparam logic [TBL_W-1:0] DEFAULT_EXPECTED     = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage : sweep_pkg

// File: rtl/settle_counter.sv
// Settle-time counter for the sweep controller.
//   clk, rst       : clock and synchronous active-high reset
//   clear          : forces the count to zero (wins over enable)
//   enable         : advance the count by one
//   terminal_count : high while the count equals LIMIT-1
module settle_counter
   import sweep_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_SETTLE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal_count
);

   logic [CNT_W-1:0] cnt;

   // Count of SETTLE cycles spent on the current vector
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign terminal_count = (cnt == CNT_W'(LIMIT - 1));

endmodule : settle_counter

// File: rtl/truth_table_sweep.sv
// Exhaustive 2-input truth-table sweep of an external gate.
//   clk, rst  : clock and synchronous active-high reset
//   start     : one-cycle request to begin a sweep (ignored while busy)
//   z         : output of the gate under test, driven from x and y
//   x, y      : applied vector, x is the MSB
//   table_out : bit i holds the z captured for {x,y}==i
//   busy      : sweep in progress
//   done      : sweep complete, held until next start or rst
//   pass      : table_out matched EXPECTED (valid while done)
module truth_table_sweep
   import sweep_pkg::*;
#(
   parameter int unsigned      SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter logic [TBL_W-1:0] EXPECTED      = DEFAULT_EXPECTED
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             z,
   output logic             x,
   output logic             y,
   output logic [TBL_W-1:0] table_out,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [TBL_W-1:0] table_nxt;
   logic             start_ok;
   logic             cnt_clear;
   logic             cnt_enable;
   logic             cnt_tc;

   // A start is honoured only when no sweep is running
   assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign cnt_clear  = start_ok || (state == ST_SAMPLE);
   assign cnt_enable = (state == ST_SETTLE);

   settle_counter #(
      .LIMIT (SETTLE_CYCLES)
   ) u_settle_counter (
      .clk            (clk),
      .rst            (rst),
      .clear          (cnt_clear),
      .enable         (cnt_enable),
      .terminal_count (cnt_tc)
   );

   // Captured table with the current vector's z merged in
   always_comb begin
      table_nxt      = table_out;
      table_nxt[idx] = z;
   end

   // Sweep controller; x/y are loaded together with idx so they track it
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         x         <= 1'b0;
         y         <= 1'b0;
         table_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  state     <= ST_SETTLE;
                  idx       <= '0;
                  x         <= 1'b0;
                  y         <= 1'b0;
                  table_out <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (cnt_tc) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               table_out <= table_nxt;
               if (idx == IDX_W'(3)) begin
                  // Last vector: hold {x,y}=11 and publish the verdict
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (table_nxt == EXPECTED);
               end else begin
                  state  <= ST_SETTLE;
                  idx    <= idx + IDX_W'(1);
                  {x, y} <= idx + IDX_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : truth_table_sweep

// File: tb/tb_truth_table_sweep.sv
// Self-checking bench: three sweep instances (AND / XOR / random gates),
// compared cycle by cycle against a timing model of the sweep.
module tb_truth_table_sweep;

   localparam int unsigned N = 3;

   logic             clk = 1'b0;
   logic [N-1:0]     rst;
   logic [N-1:0]     start;
   logic [N-1:0]     z;
   logic [N-1:0]     noise;
   logic [N-1:0]     x;
   logic [N-1:0]     y;
   logic [N-1:0]     busy;
   logic [N-1:0]     done;
   logic [N-1:0]     pass;
   logic [3:0]       tbl     [N];
   logic [3:0]       gate_tt [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Behavioural gates under test, with optional glitch injection
   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         z[i] = gate_tt[i][{x[i], y[i]}] ^ noise[i];
      end
   end

   // Default parameters, AND gate
   truth_table_sweep u_dut0 (
      .clk (clk), .rst (rst[0]), .start (start[0]), .z (z[0]),
      .x (x[0]), .y (y[0]), .table_out (tbl[0]),
      .busy (busy[0]), .done (done[0]), .pass (pass[0])
   );

   // XOR gate against the AND golden table
   truth_table_sweep #(.SETTLE_CYCLES(7), .EXPECTED(4'b1000)) u_dut1 (
      .clk (clk), .rst (rst[1]), .start (start[1]), .z (z[1]),
      .x (x[1]), .y (y[1]), .table_out (tbl[1]),
      .busy (busy[1]), .done (done[1]), .pass (pass[1])
   );

   // Minimum settle time, random gates
   truth_table_sweep #(.SETTLE_CYCLES(1), .EXPECTED(4'b0110)) u_dut2 (
      .clk (clk), .rst (rst[2]), .start (start[2]), .z (z[2]),
      .x (x[2]), .y (y[2]), .table_out (tbl[2]),
      .busy (busy[2]), .done (done[2]), .pass (pass[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {busy, done, pass, x, y, table_out}
   function automatic logic [8:0] obs(input int sel);
      return {busy[sel], done[sel], pass[sel], x[sel], y[sel], tbl[sel]};
   endfunction

   // Expected outputs k cycles after the first SETTLE cycle
   function automatic logic [8:0] model(input int k, input int sc,
                                        input logic [3:0] gate, input logic [3:0] golden);
      int          per = sc + 1;
      logic [3:0]  t   = '0;
      logic [1:0]  v;
      if (k >= 4 * per) return {1'b0, 1'b1, gate == golden, 2'b11, gate};
      for (int j = 0; j < 4; j++)
         if ((j + 1) * per <= k) t[j] = gate[j];
      v = 2'(k / per);
      return {1'b1, 1'b0, 1'b0, v, t};
   endfunction

   // Run one sweep on instance sel; optionally re-pulse start or abort with rst
   task automatic run_sweep(input int sel, input int sc, input logic [3:0] golden,
                            input logic [3:0] gate, input int restart_at,
                            input int abort_at, input bit noisy, input string tag);
      int per = sc + 1;
      gate_tt[sel] = gate;
      start[sel]   = 1'b1;
      step();
      start[sel]   = 1'b0;
      for (int k = 0; k <= 4 * per; k++) begin
         if (k == abort_at) begin
            rst[sel] = 1'b1;
            step();
            rst[sel] = 1'b0;
            check({tag, "_abort"}, 32'(obs(sel)), 32'd0);
            noise[sel] = 1'b0;
            return;
         end
         check(tag, 32'(obs(sel)), 32'(model(k, sc, gate, golden)));
         start[sel] = (k == restart_at);
         // Glitch z freely except on the edge that closes a SAMPLE cycle
         noise[sel] = noisy && ((k % per) != sc) ? 1'($urandom) : 1'b0;
         if (k < 4 * per) step();
      end
      start[sel] = 1'b0;
      // DONE must hold regardless of z activity
      for (int h = 0; h < 3; h++) begin
         noise[sel] = noisy ? 1'($urandom) : 1'b0;
         step();
         check({tag, "_hold"}, 32'(obs(sel)), 32'(model(4 * per, sc, gate, golden)));
      end
      noise[sel] = 1'b0;
   endtask

   initial begin
      int ab;
      logic [3:0] g;
      rst   = '1;
      start = '0;
      noise = '0;
      for (int i = 0; i < int'(N); i++) gate_tt[i] = 4'b0000;
      step();
      step();
      for (int i = 0; i < int'(N); i++) check("reset", 32'(obs(i)), 32'd0);
      rst = '0;
      step();

      // AND gate, default timing, then restart from DONE with a stray start at cycle 50
      run_sweep(0, 100, 4'b1000, 4'b1000, -1, -1, 1'b1, "and");
      run_sweep(0, 100, 4'b1000, 4'b1000, 50, -1, 1'b0, "and_restart");

      // Abort while idx==2, then a full fresh sweep
      ab = 2 * 101 + int'($urandom_range(0, 100));
      run_sweep(0, 100, 4'b1000, 4'b1000, -1, ab, 1'b0, "and_rst");
      step();
      check("post_abort_idle", 32'(obs(0)), 32'd0);
      run_sweep(0, 100, 4'b1000, 4'b1000, -1, -1, 1'b0, "and_fresh");

      // start together with rst: stays idle
      rst[0] = 1'b1; start[0] = 1'b1;
      step();
      rst[0] = 1'b0; start[0] = 1'b0;
      check("rst_start", 32'(obs(0)), 32'd0);
      step();
      check("rst_start_idle", 32'(obs(0)), 32'd0);

      // XOR against AND golden table
      run_sweep(1, 7, 4'b1000, 4'b0110, -1, -1, 1'b1, "xor");
      run_sweep(1, 7, 4'b1000, 4'b0110, 3, -1, 1'b1, "xor_again");

      // SETTLE_CYCLES=1 with random gates; one sweep forced to the golden table
      run_sweep(2, 1, 4'b0110, 4'b0110, -1, -1, 1'b0, "sc1_match");
      for (int r = 0; r < 20; r++) begin
         g = 4'($urandom);
         run_sweep(2, 1, 4'b0110, g, int'($urandom_range(0, 9)) - 1, -1, 1'b1, "sc1_rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_truth_table_sweep

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The parameter SETTLE_CYCLES SHALL default to 100 and set the clock cycles each {x,y} vector is held before z is sampled; its legal range SHALL be 1..65535.
REQ-002 The parameter EXPECTED SHALL be 4 bits wide, default 4'b1000 (AND gate), and give the golden truth table indexed by {x,y}.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state SHALL update on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and be a synchronous, active-high reset.
REQ-005 The port start SHALL be an input, 1 bit wide, and be a one-cycle request to begin a sweep.
REQ-006 The port z SHALL be an input, 1 bit wide, and be the output of the gate under test, driven from x and y.
REQ-007 The port x SHALL be an output, 1 bit wide, and be the MSB of the applied vector, driven from a register.
REQ-008 The port y SHALL be an output, 1 bit wide, and be the LSB of the applied vector, driven from a register.
REQ-009 The port table_out SHALL be an output, 4 bits wide, with bit i holding the z captured for {x,y}==i.
REQ-010 The port busy SHALL be an output, 1 bit wide, and be high while a sweep is in progress.
REQ-011 The port done SHALL be an output, 1 bit wide, and be a level that goes high when the sweep completes and holds until the next start or rst.
REQ-012 The port pass SHALL be an output, 1 bit wide, equal to (table_out==EXPECTED) while done is high, and 0 otherwise.

Function
REQ-013 The block SHALL implement states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE or DONE, a start SHALL clear table_out, idx and cnt, drop done, and move to SETTLE; busy SHALL be high from the next cycle.
REQ-015 In SETTLE, {x,y} SHALL equal the 2-bit idx and cnt (16-bit) SHALL increment each cycle.
REQ-016 When cnt==SETTLE_CYCLES-1, the state SHALL move to SAMPLE.
REQ-017 In SAMPLE, table_out[idx] SHALL be set to z.
REQ-018 From SAMPLE with idx<3, the block SHALL set idx to idx+1, set cnt to 0 and return to SETTLE.
REQ-019 From SAMPLE with idx==3, the block SHALL go to DONE, with busy low and done high.
REQ-020 Each vector SHALL take exactly SETTLE_CYCLES+1 cycles.
REQ-021 done SHALL rise 4*(SETTLE_CYCLES+1) cycles after the first SETTLE cycle, which is 404 cycles at the default.
REQ-022 start SHALL be ignored while busy is high.
REQ-023 In DONE, {x,y} SHALL hold 2'b11 and table_out SHALL hold its captured value.
REQ-024 idx SHALL never wrap; a fifth vector SHALL never be applied.
REQ-025 z SHALL be sampled only in SAMPLE; changes on z at any other time SHALL NOT affect table_out.

Reset
REQ-026 While rst is high, the state SHALL be IDLE and x, y, table_out, busy, done, pass, idx and cnt SHALL all be 0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst asserted mid-sweep SHALL abort the sweep in that cycle, with no partial result retained.

Structure
REQ-029 The state encoding and the default SETTLE_CYCLES and EXPECTED constants SHALL reside in the shared package sweep_pkg.
REQ-030 The settle counter SHALL be a sub-module, settle_counter, with inputs clear and enable and output terminal_count.

Verification
REQ-031 The bench SHALL check this scenario: with a 2-input AND as the gate under test and default parameters, pulse start -> {x,y} steps 00,01,10,11 every 101 cycles, done after 404 cycles, table_out=4'b1000, pass=1.
REQ-032 The bench SHALL check this scenario: with an XOR as the gate under test and EXPECTED=4'b1000 -> table_out=4'b0110, pass=0, done=1.
REQ-033 The bench SHALL check this scenario: start pulsed again at cycle 50 of a sweep -> ignored, and the sweep timing is unchanged.
REQ-034 The bench SHALL check this scenario: rst asserted while idx=2 -> the next cycle shows all outputs 0 and IDLE, and a subsequent start gives a full fresh sweep.
REQ-035 The bench SHALL check this scenario: SETTLE_CYCLES=1 -> each vector lasts 2 cycles, and done arrives 8 cycles after the first SETTLE cycle.
REQ-036 The bench SHALL check this scenario: start in the same cycle as rst -> stays in IDLE; start while in DONE -> done drops the next cycle and a new sweep begins.
